// File: rtl/ram_view_pkg.sv
// Shared widths, blanking pattern and FSM encoding for the RAM viewer.
package ram_view_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;
endpackage

// File: rtl/fnd_enc.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module fnd_enc (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/ram_view_ctrl.sv
// Walks a 32-entry RAM one address at a time (timer or step pulse) and
// shows address and data on four 7-segment digits.
module ram_view_ctrl
  import ram_view_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              disp_valid,
  output logic [6:0]        hex3,
  output logic [6:0]        hex2,
  output logic [6:0]        hex1,
  output logic [6:0]        hex0
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int WW = $clog2(RD_LAT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [TW-1:0]     tick;
  logic [WW-1:0]     wcnt;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;

  assign rd_addr = cur_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ISSUE;
      cur_addr   <= '0;
      tick       <= '0;
      wcnt       <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      rd_en      <= 1'b0;
    end else begin
      case (state)
        // Entered from SHOW with the strobe already armed; out of reset it
        // is armed here first, so the strobe is still a single cycle.
        ST_ISSUE: begin
          if (rd_en) begin
            rd_en <= 1'b0;
            wcnt  <= '0;
            state <= ST_WAIT;
          end else begin
            rd_en <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (wcnt == WAIT_LAST) begin
            disp_data  <= rd_data;
            disp_addr  <= cur_addr;
            disp_valid <= 1'b1;
            state      <= ST_SHOW;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (step || (run && tick == TICK_LAST)) begin
            tick     <= '0;
            cur_addr <= cur_addr + 1'b1;
            rd_en    <= 1'b1;
            state    <= ST_ISSUE;
          end else if (run) begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= ST_ISSUE;
      endcase
    end
  end

  logic [3:0][3:0] nib;
  logic [3:0][6:0] seg;

  assign nib[3] = {3'b000, disp_addr[4]};
  assign nib[2] = disp_addr[3:0];
  assign nib[1] = disp_data[7:4];
  assign nib[0] = disp_data[3:0];

  for (genvar d = 0; d < 4; d++) begin : g_dig
    fnd_enc u_enc (.hex(nib[d]), .seg(seg[d]));
  end

  assign hex3 = disp_valid ? seg[3] : BLANK;
  assign hex2 = disp_valid ? seg[2] : BLANK;
  assign hex1 = disp_valid ? seg[1] : BLANK;
  assign hex0 = disp_valid ? seg[0] : BLANK;
endmodule

// File: tb/tb_ram_view_ctrl.sv
// Randomized bench for ram_view_ctrl against a timestamp-based display model.
module tb_ram_view_ctrl;
  localparam int TD = 4;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [4:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       disp_valid;
  logic [6:0] hex3, hex2, hex1, hex0;

  always #5 clk = ~clk;

  ram_view_ctrl #(.TICK_DIV(TD), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .disp_valid(disp_valid),
    .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  // RAM: data is only meaningful RL cycles after a strobed read
  logic [7:0] mem [32];
  logic [7:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= rd_en ? mem[rd_addr] : 8'hEE;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign rd_data = pipe[RL-1];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  function automatic logic [6:0] enc(input logic [3:0] v);
    return seg_tab[v];
  endfunction

  int total = 0;
  int bad = 0;

  // Model: cycles counted from reset release; a fetch strobed in cycle f
  // lands on the display at the end of cycle f+RL; SHOW starts at f+RL+1.
  int         c, fetch_cyc, ticks;
  logic [4:0] m_addr, m_daddr;
  logic [7:0] m_ddata;
  bit         m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, c);
    end
  endtask

  function automatic bit showing();
    return c >= fetch_cyc + RL + 1;
  endfunction

  task automatic model_reset();
    c = 0; fetch_cyc = 1; ticks = 0;
    m_addr = '0; m_daddr = '0; m_ddata = '0; m_valid = 0;
  endtask

  task automatic model_edge(input bit r, input bit s);
    if (c == fetch_cyc + RL) begin
      m_ddata = mem[m_addr];
      m_daddr = m_addr;
      m_valid = 1;
    end
    if (showing()) begin
      if (s || (r && ticks == TD - 1)) begin
        m_addr++;
        ticks = 0;
        fetch_cyc = c + 1;
      end else if (r) begin
        ticks++;
      end
    end
    c++;
  endtask

  function automatic logic [27:0] exp_hex();
    if (!m_valid) return {4{7'h7F}};
    return {enc({3'b000, m_daddr[4]}), enc(m_daddr[3:0]), enc(m_ddata[7:4]), enc(m_ddata[3:0])};
  endfunction

  task automatic compare();
    chk("rd_en", rd_en, (c == fetch_cyc));
    chk("rd_addr", rd_addr, m_addr);
    chk("disp_valid", disp_valid, m_valid);
    chk("hex", {hex3, hex2, hex1, hex0}, exp_hex());
  endtask

  task automatic cycle(input bit r, input bit s);
    run = r; step = s;
    @(posedge clk);
    model_edge(r, s);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    chk("rst_hex", {hex3, hex2, hex1, hex0}, {4{7'h7F}});
    chk("rst_valid", disp_valid, 1'b0);
    chk("rst_rden", rd_en, 1'b0);
    chk("rst_addr", rd_addr, 5'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    compare();
  endtask

  task automatic post_reset_check();
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0);
      pulses += int'(rd_en);
      if (c == 3) chk("blank_c3", {hex3, hex2, hex1, hex0}, {4{7'h7F}});
      if (c == 4) chk("first_show", {hex3, hex2, hex1, hex0}, {7'h40, 7'h40, 7'h08, 7'h40});
    end
    chk("rd_en_pulses", pulses, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [4:0] a0;
    for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
    mem[31] = 8'h5C;
    model_reset();
    #2;
    do_reset(2);
    post_reset_check();

    // free run: one advance every TD+RL+1 cycles
    for (int i = 0; i < 40; i++) cycle(1, 0);
    chk("run40_addr", rd_addr, 5'd6);

    // run up to address 31, then check wrap
    n = 0;
    while (!(m_valid && m_daddr == 5'd31 && showing()) && n < 400) begin
      cycle(1, 0); n++;
    end
    chk("reach31_timeout", (n < 400), 1'b1);
    chk("hex_31", {hex3, hex2, hex1, hex0}, {7'h79, 7'h0E, 7'h12, 7'h46});
    n = 0;
    while (rd_addr == 5'd31 && n < 10) begin
      cycle(1, 0); n++;
    end
    chk("wrap_addr", rd_addr, 5'd0);

    // step latency and step during WAIT
    n = 0;
    while (!showing() && n < 20) begin
      cycle(0, 0); n++;
    end
    a0 = rd_addr;
    cycle(0, 1);
    chk("step_rden_s1", rd_en, 1'b1);
    chk("step_addr_s1", rd_addr, a0 + 5'd1);
    cycle(0, 0);
    cycle(0, 1);
    chk("wait_rden_s3", rd_en, 1'b0);
    cycle(0, 0);
    chk("step_show_s4", {hex2, hex1, hex0},
        {enc(4'(a0 + 5'd1)), enc(mem[a0 + 5'd1][7:4]), enc(mem[a0 + 5'd1][3:0])});
    for (int i = 0; i < 10; i++) cycle(0, 0);
    chk("step_once", rd_addr, a0 + 5'd1);

    // step coincident with tick expiry
    n = 0;
    while (!(showing() && ticks == TD - 1) && n < 20) begin
      cycle(1, 0); n++;
    end
    a0 = rd_addr;
    cycle(1, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0);
    chk("coincident_once", rd_addr, a0 + 5'd1);

    // randomized run/step mix
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      cycle(run, ($urandom_range(0, 5) == 0));
    end

    // reset in WAIT at address 7 discards the in-flight read
    n = 0;
    while (!(m_addr == 5'd7 && c == fetch_cyc + 1) && n < 400) begin
      cycle(0, showing() && m_addr != 5'd7);
      n++;
    end
    chk("reach7_timeout", (n < 400), 1'b1);
    chk("addr7", rd_addr, 5'd7);
    do_reset(2);
    post_reset_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_view_ctrl.md
RAM_VIEW_CTRL -- requirements
Module: ram_view_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, auto-advance period in clk cycles (minimum 2).
REQ-002 SHALL have parameter RD_LAT, default 2, RAM read latency in cycles from rd_en to valid rd_data (minimum 1).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port run, input, 1, level; when high, the address auto-advances every TICK_DIV cycles.
REQ-006 SHALL have port step, input, 1, single-cycle pulse (already debounced); advances by one address.
REQ-007 SHALL have port rd_addr, output, 5, read address to the RAM read port.
REQ-008 SHALL have port rd_en, output, 1, read strobe to the RAM read port.
REQ-009 SHALL have port rd_data, input, 8, RAM read data.
REQ-010 SHALL have port disp_valid, output, 1, high once the first capture is complete.
REQ-011 SHALL have ports hex3, hex2, hex1, hex0, output, 7 each, active-low segments ordered {g,f,e,d,c,b,a}.

Function
REQ-012 SHALL implement FSM states ISSUE, WAIT, SHOW.
REQ-013 SHALL drive rd_addr from the internal register cur_addr at all times.
REQ-014 ISSUE SHALL assert rd_en for exactly one cycle, then go to WAIT.
REQ-015 WAIT SHALL last exactly RD_LAT cycles.
- On the clock edge ending the last WAIT cycle: capture rd_data into disp_data, cur_addr into disp_addr, set disp_valid=1, go to SHOW.
REQ-016 rd_en SHALL be 0 in WAIT and SHOW.
REQ-017 In SHOW with run=1, the tick counter SHALL increment each cycle.
- At count TICK_DIV-1: clear the counter, increment cur_addr, go to ISSUE.
REQ-018 In SHOW with run=0, the tick counter SHALL hold its value.
REQ-019 step=1 in SHOW SHALL clear the tick counter, increment cur_addr and go to ISSUE, regardless of run.
- step and tick-expiry in the same cycle SHALL produce a single increment.
REQ-020 step during ISSUE or WAIT SHALL be ignored and not queued.
REQ-021 cur_addr SHALL wrap from 31 to 0.
REQ-022 Latency: step in SHOW at cycle S SHALL give rd_en at S+1 and updated hex outputs visible at S+RD_LAT+2.
REQ-023 With disp_valid=1, the hex outputs SHALL show:
- hex3 = encode({3'b000, disp_addr[4]})
- hex2 = encode(disp_addr[3:0])
- hex1 = encode(disp_data[7:4])
- hex0 = encode(disp_data[3:0])
- encode is the standard active-low hex-digit table (0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E).
REQ-024 With disp_valid=0, all hex outputs SHALL be blank (7'h7F).
REQ-025 Hex outputs SHALL be combinational from the disp registers (no extra register stage).

Reset
REQ-026 rst_n low SHALL asynchronously force:
- state=ISSUE, cur_addr=0, tick counter=0
- disp_addr=0, disp_data=0, disp_valid=0
- rd_en=0, all hex outputs 7'h7F
REQ-027 After rst_n deasserts, the first cycle SHALL be ISSUE, fetching address 0.
REQ-028 Reset mid-read SHALL discard the in-flight read; no capture SHALL occur after reset.

Structure
REQ-029 Package ram_view_pkg SHALL hold:
- state encoding constants
- ADDR_W=5, DATA_W=8
- BLANK=7'h7F
REQ-030 SHALL instantiate four copies of the existing fnd_enc 7-segment encoder as the only sub-module.
REQ-031 Tick counter width SHALL be clog2(TICK_DIV); the RD_LAT counter width SHALL be clog2(RD_LAT+1).

Verification (TICK_DIV=4, RD_LAT=2; RAM model with 2-cycle latency, mem[i]=8'hA0+i)
REQ-032 Reset release, run=0:
- rd_en pulses once at addr 0
- hex outputs 7'h7F until cycle 4, then hex3/hex2/hex1/hex0 = 0/0/A/0 (7'h40, 7'h40, 7'h08, 7'h40)
- no further rd_en pulses
REQ-033 run=1 for 40 cycles: addresses advance 0,1,2,... with one advance every 4+RD_LAT+1=7 cycles; disp_data tracks 8'hA0+addr.
REQ-034 Advance past address 31 (mem[31] preset to 8'h5C): hex shows 1/F/5/C, and the next address is 0.
REQ-035 step in SHOW -> rd_en at S+1, new display at S+4; a second step during WAIT is ignored, giving exactly one increment.
REQ-036 rst_n pulsed low during WAIT at address 7 -> outputs blank immediately; after release, address 0 is displayed and no stale capture of address 7 occurs.
REQ-037 step coincident with tick expiry -> cur_addr increments by exactly 1.
